// File: rtl/vote_tally.sv
// vote_tally: per-candidate vote counter with post-vote lockout and result readout.
// Optional running total of accepted votes when VOTE_TALLY_TOTAL_EN is defined.
`default_nettype none

module vote_tally #(
  parameter int NUM_CAND       = 4,
  parameter int COUNT_W        = 8,
  parameter int LOCKOUT_CYCLES = 100000000
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                mode_i,
  input  logic [NUM_CAND-1:0] valid_vote_i,
  input  logic [NUM_CAND-1:0] cand_sel_i,
  output logic [COUNT_W-1:0]  count_out_o,
  output logic                vote_ack_o,
  output logic                vote_err_o
`ifdef VOTE_TALLY_TOTAL_EN
  ,
  output logic [COUNT_W+$clog2(NUM_CAND)-1:0] total_out_o
`endif
);

  localparam int CNT_W = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [1:0] S_VOTE   = 2'd0;
  localparam logic [1:0] S_LOCK   = 2'd1;
  localparam logic [1:0] S_RESULT = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [COUNT_W-1:0] tally_q [NUM_CAND];
  logic [COUNT_W-1:0] count_q, count_d;
  logic               err_q, err_d;

  logic               w_seen;
  logic               w_multi;
  logic               w_accept;
  logic               w_lock_done;
  logic [COUNT_W-1:0] w_sel_val;

  always_comb begin
    w_seen  = 1'b0;
    w_multi = 1'b0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (valid_vote_i[i]) begin
        if (w_seen) w_multi = 1'b1;
        w_seen = 1'b1;
      end
    end
  end

  // A vote is only taken in VOTE with mode low; mode wins over a same-cycle pulse.
  assign w_accept    = (state_q == S_VOTE) && !mode_i && w_seen && !w_multi;
  assign w_lock_done = (lock_cnt_q == CNT_W'(1));

  // Descending scan so the lowest set select bit has the final say.
  always_comb begin
    w_sel_val = '0;
    for (int i = NUM_CAND - 1; i >= 0; i--) begin
      if (cand_sel_i[i]) w_sel_val = tally_q[i];
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= S_VOTE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_VOTE: begin
        if (mode_i)        state_d = S_RESULT;
        else if (w_accept) state_d = S_LOCK;
      end
      S_LOCK: begin
        if (w_lock_done) state_d = mode_i ? S_RESULT : S_VOTE;
      end
      S_RESULT: begin
        if (!mode_i) state_d = S_VOTE;
      end
      default: state_d = S_VOTE;
    endcase
  end

  always_comb begin
    vote_ack_o = (state_q == S_LOCK);
  end

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (w_accept)                lock_cnt_d = CNT_W'(LOCKOUT_CYCLES);
    else if (state_q == S_LOCK)  lock_cnt_d = lock_cnt_q - 1'b1;
  end

  // Readout is zeroed on the cycle mode drops so VOTE always sees count_out = 0.
  assign count_d = ((state_q == S_RESULT) && mode_i) ? w_sel_val : '0;
  assign err_d   = (state_q == S_VOTE) && !mode_i && w_multi;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      lock_cnt_q <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= '0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      count_q    <= count_d;
      err_q      <= err_d;
      for (int i = 0; i < NUM_CAND; i++) begin
        if (w_accept && valid_vote_i[i] && (tally_q[i] != '1))
          tally_q[i] <= tally_q[i] + 1'b1;
      end
    end
  end

  assign count_out_o = count_q;
  assign vote_err_o  = err_q;

`ifdef VOTE_TALLY_TOTAL_EN
  logic [COUNT_W+$clog2(NUM_CAND)-1:0] total_q;

  always_ff @(posedge clock_i) begin
    if (reset_i)                       total_q <= '0;
    else if (w_accept && (total_q != '1)) total_q <= total_q + 1'b1;
  end

  assign total_out_o = total_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vote_tally.sv
// tb_vote_tally: directed stimulus for vote_tally, checked every cycle against a
// cycle-level behavioural model plus literal expectations from the test plan.
`default_nettype none

module tb_vote_tally;

  localparam int NC  = 4;
  localparam int CW  = 4;
  localparam int LC  = 4;
  localparam int TW  = CW + $clog2(NC);
  localparam int MAXC = (1 << CW) - 1;
  localparam int MAXT = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          mode;
  logic [NC-1:0] valid_vote;
  logic [NC-1:0] cand_sel;
  logic [CW-1:0] count_out;
  logic          vote_ack;
  logic          vote_err;
`ifdef VOTE_TALLY_TOTAL_EN
  logic [TW-1:0] total_out;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  vote_tally #(
    .NUM_CAND      (NC),
    .COUNT_W       (CW),
    .LOCKOUT_CYCLES(LC)
  ) dut (
    .clock_i     (clk),
    .reset_i     (reset),
    .mode_i      (mode),
    .valid_vote_i(valid_vote),
    .cand_sel_i  (cand_sel),
    .count_out_o (count_out),
    .vote_ack_o  (vote_ack),
    .vote_err_o  (vote_err)
`ifdef VOTE_TALLY_TOTAL_EN
    ,
    .total_out_o (total_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_set(input logic [NC-1:0] v);
    for (int i = 0; i < NC; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Model: ack cycles still owed, whether we are displaying results, and the
  // output values expected during the current cycle.
  int m_tally [NC];
  int m_lock_left;
  bit m_result;
  int m_err;
  int m_cnt;
  int m_total;
  bit m_on = 1'b0;

  always @(posedge clk) begin
    int n_err;
    int n_cnt;
    int sel;
    n_err = 0;
    n_cnt = 0;
    if (reset) begin
      for (int i = 0; i < NC; i++) m_tally[i] = 0;
      m_lock_left = 0;
      m_result    = 1'b0;
      m_total     = 0;
      m_on        = 1'b1;
    end else if (m_on) begin
      if (m_lock_left > 0) begin
        m_lock_left--;
        if (m_lock_left == 0 && mode) m_result = 1'b1;
      end else if (m_result) begin
        if (mode) begin
          sel = lowest_set(cand_sel);
          n_cnt = (sel < 0) ? 0 : m_tally[sel];
        end else begin
          m_result = 1'b0;
        end
      end else if (mode) begin
        m_result = 1'b1;
      end else if ($countones(valid_vote) == 1) begin
        sel = lowest_set(valid_vote);
        if (m_tally[sel] < MAXC) m_tally[sel]++;
        if (m_total < MAXT) m_total++;
        m_lock_left = LC;
      end else if ($countones(valid_vote) > 1) begin
        n_err = 1;
      end
    end
    m_err = n_err;
    m_cnt = n_cnt;
  end

  always @(negedge clk) begin
    if (m_on) begin
      check("model_ack",   int'(vote_ack),  int'(m_lock_left > 0));
      check("model_err",   int'(vote_err),  m_err);
      check("model_count", int'(count_out), m_cnt);
`ifdef VOTE_TALLY_TOTAL_EN
      check("model_total", int'(total_out), m_total);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic enter_result();
    mode = 1'b1;
    step();
  endtask

  task automatic read_tally(input string name, input logic [NC-1:0] sel, input int exp);
    cand_sel = sel;
    step();
    @(negedge clk);
    check(name, int'(count_out), exp);
  endtask

  task automatic leave_result();
    mode = 1'b0;
    step();
    @(negedge clk);
    check("leave_count_zero", int'(count_out), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    mode       = 1'b0;
    valid_vote = '0;
    cand_sel   = '0;
    step_n(2);
    @(negedge clk);
    check("reset_ack",   int'(vote_ack),  0);
    check("reset_err",   int'(vote_err),  0);
    check("reset_count", int'(count_out), 0);
    reset = 1'b0;

    // Single vote and its lockout window.
    valid_vote = 4'b0001;
    step();
    valid_vote = '0;
    for (int k = 1; k <= LC; k++) begin
      @(negedge clk);
      check("single_ack_high", int'(vote_ack), 1);
      step();
    end
    @(negedge clk);
    check("single_ack_low", int'(vote_ack), 0);
    cand_sel = 4'b0001;
    enter_result();
    @(negedge clk);
    check("result_first_cycle", int'(count_out), 0);
    read_tally("single_cand0", 4'b0001, 1);
    read_tally("single_cand1", 4'b0010, 0);
    leave_result();

    // Lockout: pulses at t, t+2, t+5.
    valid_vote = 4'b0010; step();
    valid_vote = '0;      step();
    valid_vote = 4'b0010; step();
    valid_vote = '0;      step_n(2);
    valid_vote = 4'b0010; step();
    valid_vote = '0;
    @(negedge clk);
    check("lockout_reaccept_ack", int'(vote_ack), 1);
    step_n(LC);
    enter_result();
    read_tally("lockout_cand1", 4'b0010, 2);
    leave_result();

    // Simultaneous pulses from a fresh reset.
    do_reset();
    valid_vote = 4'b0101; step();
    valid_vote = 4'b0100;
    @(negedge clk);
    check("multi_err_pulse", int'(vote_err), 1);
    check("multi_no_ack",    int'(vote_ack), 0);
    step();
    valid_vote = '0;
    @(negedge clk);
    check("multi_err_one_cycle", int'(vote_err), 0);
    check("multi_next_ack",      int'(vote_ack), 1);
    step_n(LC);
    enter_result();
    read_tally("multi_cand0", 4'b0001, 0);
    read_tally("multi_cand2", 4'b0100, 1);
    read_tally("multi_cand3", 4'b1000, 0);
    read_tally("multi_sel_none", 4'b0000, 0);
    leave_result();

    // Saturation: 20 votes for candidate 3.
    do_reset();
    for (int v = 0; v < 20; v++) begin
      valid_vote = 4'b1000; step();
      valid_vote = '0;      step_n(LC);
    end
    enter_result();
    read_tally("sat_cand3", 4'b1000, 15);
`ifdef VOTE_TALLY_TOTAL_EN
    check("sat_total", int'(total_out), 20);
`endif
    leave_result();

    // Reset in the middle of a lockout.
    valid_vote = 4'b0001; step();
    valid_vote = '0;      step();
    reset = 1'b1;         step();
    reset = 1'b0;
    valid_vote = 4'b0010;
    @(negedge clk);
    check("midlock_ack_cleared", int'(vote_ack), 0);
    step();
    valid_vote = '0;
    @(negedge clk);
    check("midlock_first_accept", int'(vote_ack), 1);
    step_n(LC);
    enter_result();
    read_tally("midlock_cand0", 4'b0001, 0);
    read_tally("midlock_cand3", 4'b1000, 0);
    read_tally("midlock_cand1", 4'b0010, 1);
    leave_result();

    // Mode and vote in the same VOTE cycle: the vote is dropped.
    mode = 1'b1;
    valid_vote = 4'b0001;
    cand_sel = 4'b0110;
    step();
    valid_vote = '0;
    @(negedge clk);
    check("collision_no_ack", int'(vote_ack), 0);
    read_tally("collision_lowest_sel", 4'b0110, 1);
    read_tally("collision_cand0", 4'b0001, 0);
    leave_result();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
